// File: rtl/boolean_sweep_ctrl_if.sv
// Bus bundle between the sweep controller, its requester and the evaluator.
interface boolean_sweep_ctrl_if;
    localparam int unsigned N_VEC = 16;
    localparam int unsigned OPW   = 4;

    logic             start;
    logic [N_VEC-1:0] exp_f1;
    logic [N_VEC-1:0] exp_f2;
    logic [OPW-1:0]   abcd;
    logic [OPW-1:0]   wxyz;
    logic             f1_in;
    logic             f2_in;
    logic             busy;
    logic             done;
    logic [N_VEC-1:0] f1_mask;
    logic [N_VEC-1:0] f2_mask;
    logic             mismatch;

    // Requester/evaluator side
    modport master (
        output start, exp_f1, exp_f2, f1_in, f2_in,
        input  abcd, wxyz, busy, done, f1_mask, f2_mask, mismatch
    );

    // Controller side
    modport slave (
        input  start, exp_f1, exp_f2, f1_in, f2_in,
        output abcd, wxyz, busy, done, f1_mask, f2_mask, mismatch
    );
endinterface

// File: rtl/boolean_sweep_ctrl.sv
// Sweeps all 16 operand indices through an external evaluator, captures the
// F1/F2 truth tables and flags any difference from the expected masks.
module boolean_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    boolean_sweep_ctrl_if.slave   bus
);
    localparam int unsigned N_VEC = 16;
    localparam int unsigned IDXW  = 4;
    localparam int unsigned WAITW = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_nxt;
    logic [IDXW-1:0]  idx_q, idx_nxt;
    logic [WAITW-1:0] wait_q, wait_nxt;
    logic [N_VEC-1:0] exp_f1_q, exp_f1_nxt;
    logic [N_VEC-1:0] exp_f2_q, exp_f2_nxt;
    logic [N_VEC-1:0] f1_mask_q, f1_mask_nxt;
    logic [N_VEC-1:0] f2_mask_q, f2_mask_nxt;
    logic             mismatch_q, mismatch_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [IDXW-1:0]  opnd_q, opnd_nxt;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            exp_f1_q   <= '0;
            exp_f2_q   <= '0;
            f1_mask_q  <= '0;
            f2_mask_q  <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            opnd_q     <= '0;
        end else begin
            state_q    <= state_nxt;
            idx_q      <= idx_nxt;
            wait_q     <= wait_nxt;
            exp_f1_q   <= exp_f1_nxt;
            exp_f2_q   <= exp_f2_nxt;
            f1_mask_q  <= f1_mask_nxt;
            f2_mask_q  <= f2_mask_nxt;
            mismatch_q <= mismatch_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            opnd_q     <= opnd_nxt;
        end
    end

    // Next-state and next-output logic; outputs describe the state being entered
    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        wait_nxt     = wait_q;
        exp_f1_nxt   = exp_f1_q;
        exp_f2_nxt   = exp_f2_q;
        f1_mask_nxt  = f1_mask_q;
        f2_mask_nxt  = f2_mask_q;
        mismatch_nxt = mismatch_q;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        opnd_nxt     = '0;

        case (state_q)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (bus.start) begin
                    state_nxt    = RUN;
                    exp_f1_nxt   = bus.exp_f1;
                    exp_f2_nxt   = bus.exp_f2;
                    f1_mask_nxt  = '0;
                    f2_mask_nxt  = '0;
                    mismatch_nxt = 1'b0;
                    idx_nxt      = '0;
                    wait_nxt     = '0;
                    busy_nxt     = 1'b1;
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                opnd_nxt = idx_q;
                if (wait_q == WAITW'(SETTLE_CYCLES)) begin
                    f1_mask_nxt[idx_q] = bus.f1_in;
                    f2_mask_nxt[idx_q] = bus.f2_in;
                    if (idx_q != IDXW'(N_VEC - 1)) begin
                        idx_nxt  = idx_q + IDXW'(1);
                        wait_nxt = '0;
                        opnd_nxt = idx_q + IDXW'(1);
                    end else begin
                        // Last vector: compare the completed tables, not the stale ones
                        state_nxt    = DONE;
                        busy_nxt     = 1'b0;
                        done_nxt     = 1'b1;
                        opnd_nxt     = '0;
                        mismatch_nxt = (f1_mask_nxt != exp_f1_q) | (f2_mask_nxt != exp_f2_q);
                    end
                end else begin
                    wait_nxt = wait_q + WAITW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.abcd     = opnd_q;
    assign bus.wxyz     = opnd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.f1_mask  = f1_mask_q;
    assign bus.f2_mask  = f2_mask_q;
    assign bus.mismatch = mismatch_q;
endmodule
